// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU control codes,
// the legal-op check and the arbiter state encoding.
package alu_share_arbiter_pkg;

  // ALU control codes understood by the shared ALU.
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StExec = 1'b1
  } arb_state_e;

  // True when the code is one the ALU actually implements.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      AluAnd, AluOr, AluAdd, AluSub, AluSlt: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arb_resp_slot.sv
// One registered response buffer with a valid/ready handshake toward its
// requester. A fill loads the payload and raises valid; valid drops on the
// edge where valid && ready.
module alu_arb_resp_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_result,
  input  logic              fill_zero,
  input  logic              fill_err,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              err,
  output logic [TAG_W-1:0]  tag
);

  // Load on fill, clear valid on consume; payload holds until refilled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid  <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
      tag    <= '0;
    end else if (fill) begin
      // The arbiter only fills an empty slot, so fill never races a consume.
      valid  <= 1'b1;
      result <= fill_result;
      zero   <= fill_zero;
      err    <= fill_err;
      tag    <= fill_tag;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each accepted legal op spends one cycle in EXEC driving the ALU, then the
// result lands in the owner's response slot. Illegal ops bypass the ALU and
// return err=1 directly. The ALU's ALUSrc select is tied to 0 at top level
// since operands arrive already resolved.
// Optional: define ALU_ARB_PERF_CNT_EN to add saturating grant/stall counters.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [3:0]        req_op0,
  input  logic [3:0]        req_op1,
  input  logic [TAG_W-1:0]  req_tag0,
  input  logic [TAG_W-1:0]  req_tag1,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_result0,
  output logic [DATA_W-1:0] resp_result1,
  output logic              resp_zero0,
  output logic              resp_zero1,
  output logic              resp_err0,
  output logic              resp_err1,
  output logic [TAG_W-1:0]  resp_tag0,
  output logic [TAG_W-1:0]  resp_tag1,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [3:0]        alu_ctrl,
`ifdef ALU_ARB_PERF_CNT_EN
  output logic [31:0]       grant_cnt0,
  output logic [31:0]       grant_cnt1,
  output logic [31:0]       stall_cnt,
`endif
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  arb_state_e       state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic [TAG_W-1:0] tag_q;

  logic [1:0]        eligible;
  logic              win_any;
  logic              win_idx;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [3:0]        sel_op;
  logic [TAG_W-1:0]  sel_tag;
  logic              sel_legal;

  logic [1:0]        fill;
  logic [DATA_W-1:0] fill_result;
  logic              fill_zero;
  logic              fill_err;
  logic [TAG_W-1:0]  fill_tag;

  // Winner selection: registered resp_valid gates eligibility, ties go away
  // from the last grant.
  always_comb begin
    eligible = (state_q == StIdle) ? (req_valid & ~resp_valid) : 2'b00;
    win_any  = |eligible;
    case (eligible)
      2'b01:   win_idx = 1'b0;
      2'b10:   win_idx = 1'b1;
      2'b11:   win_idx = ~last_grant_q;
      default: win_idx = 1'b0;
    endcase
    req_ready = win_any ? (win_idx ? 2'b10 : 2'b01) : 2'b00;
  end

  // Request fields of the current winner.
  always_comb begin
    sel_a     = win_idx ? req_a1   : req_a0;
    sel_b     = win_idx ? req_b1   : req_b0;
    sel_op    = win_idx ? req_op1  : req_op0;
    sel_tag   = win_idx ? req_tag1 : req_tag0;
    sel_legal = is_legal_op(sel_op);
  end

  // Arbiter FSM; the ALU drive is registered and non-zero only during EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      tag_q        <= '0;
      alu_data1    <= '0;
      alu_data2    <= '0;
      alu_ctrl     <= AluAnd;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_any) begin
            last_grant_q <= win_idx;
            owner_q      <= win_idx;
            tag_q        <= sel_tag;
            if (sel_legal) begin
              state_q   <= StExec;
              alu_data1 <= sel_a;
              alu_data2 <= sel_b;
              alu_ctrl  <= sel_op;
            end
          end
        end
        StExec: begin
          state_q   <= StIdle;
          alu_data1 <= '0;
          alu_data2 <= '0;
          alu_ctrl  <= AluAnd;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Slot fill: ALU capture at the end of EXEC, or an immediate error reply.
  always_comb begin
    fill        = 2'b00;
    fill_result = '0;
    fill_zero   = 1'b0;
    fill_err    = 1'b0;
    fill_tag    = tag_q;
    if (state_q == StExec) begin
      fill[owner_q] = 1'b1;
      fill_result   = alu_result;
      fill_zero     = alu_zero;
    end else if (win_any && !sel_legal) begin
      fill[win_idx] = 1'b1;
      fill_err      = 1'b1;
      fill_tag      = sel_tag;
    end
  end

  alu_arb_resp_slot #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_slot0 (
    .clk         (clk),
    .reset       (reset),
    .fill        (fill[0]),
    .fill_result (fill_result),
    .fill_zero   (fill_zero),
    .fill_err    (fill_err),
    .fill_tag    (fill_tag),
    .ready       (resp_ready[0]),
    .valid       (resp_valid[0]),
    .result      (resp_result0),
    .zero        (resp_zero0),
    .err         (resp_err0),
    .tag         (resp_tag0)
  );

  alu_arb_resp_slot #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_slot1 (
    .clk         (clk),
    .reset       (reset),
    .fill        (fill[1]),
    .fill_result (fill_result),
    .fill_zero   (fill_zero),
    .fill_err    (fill_err),
    .fill_tag    (fill_tag),
    .ready       (resp_ready[1]),
    .valid       (resp_valid[1]),
    .result      (resp_result1),
    .zero        (resp_zero1),
    .err         (resp_err1),
    .tag         (resp_tag1)
  );

`ifdef ALU_ARB_PERF_CNT_EN
  // Saturating accept and stall counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      stall_cnt  <= '0;
    end else begin
      if (win_any && !win_idx && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (win_any && win_idx && (grant_cnt1 != '1))  grant_cnt1 <= grant_cnt1 + 32'd1;
      if ((|(req_valid & ~req_ready)) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU.
module tb_alu_share_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]        req_op0, req_op1;
  logic [TAG_W-1:0]  req_tag0, req_tag1;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [DATA_W-1:0] resp_result0, resp_result1;
  logic              resp_zero0, resp_zero1;
  logic              resp_err0, resp_err1;
  logic [TAG_W-1:0]  resp_tag0, resp_tag1;
  logic [DATA_W-1:0] alu_data1, alu_data2;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
`ifdef ALU_ARB_PERF_CNT_EN
  logic [31:0]       grant_cnt0, grant_cnt1, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_data1 & alu_data2;
      4'b0001: alu_result = alu_data1 | alu_data2;
      4'b0010: alu_result = alu_data1 + alu_data2;
      4'b0110: alu_result = alu_data1 - alu_data2;
      4'b0111: alu_result = ($signed(alu_data1) < $signed(alu_data2)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  alu_share_arbiter #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a0       (req_a0),
    .req_b0       (req_b0),
    .req_a1       (req_a1),
    .req_b1       (req_b1),
    .req_op0      (req_op0),
    .req_op1      (req_op1),
    .req_tag0     (req_tag0),
    .req_tag1     (req_tag1),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result0 (resp_result0),
    .resp_result1 (resp_result1),
    .resp_zero0   (resp_zero0),
    .resp_zero1   (resp_zero1),
    .resp_err0    (resp_err0),
    .resp_err1    (resp_err1),
    .resp_tag0    (resp_tag0),
    .resp_tag1    (resp_tag1),
    .alu_data1    (alu_data1),
    .alu_data2    (alu_data2),
    .alu_ctrl     (alu_ctrl),
`ifdef ALU_ARB_PERF_CNT_EN
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .stall_cnt    (stall_cnt),
`endif
    .alu_result   (alu_result),
    .alu_zero     (alu_zero)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_op0 = 4'b0000; req_op1 = 4'b0000; req_tag0 = '0; req_tag1 = '0;
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
    chk("rst_alu_data1", alu_data1, 32'h0);
    chk("rst_result0", resp_result0, 32'h0);
    reset = 1'b0;
    step();

    // Requester 0 alone: ADD 5+7 tag 3.
    req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = 4'b0010; req_tag0 = 4'd3;
    #1;
    chk("add_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    chk("add_exec_ctrl", 32'(alu_ctrl), 32'h2);
    chk("add_exec_data1", alu_data1, 32'd5);
    chk("add_exec_noresp", 32'(resp_valid), 32'h0);
    step();
    chk("add_resp_valid", 32'(resp_valid), 32'h1);
    chk("add_result0", resp_result0, 32'd12);
    chk("add_zero0", 32'(resp_zero0), 32'h0);
    chk("add_tag0", 32'(resp_tag0), 32'd3);
    chk("add_err0", 32'(resp_err0), 32'h0);
    chk("add_idle_ctrl", 32'(alu_ctrl), 32'h0);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    chk("add_consumed", 32'(resp_valid), 32'h0);

    // Illegal op on requester 1 bypasses the ALU.
    req_valid = 2'b10; req_a1 = 32'h55; req_b1 = 32'h1; req_op1 = 4'b1111; req_tag1 = 4'd5;
    #1;
    chk("ill_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    chk("ill_resp_valid", 32'(resp_valid), 32'h2);
    chk("ill_err1", 32'(resp_err1), 32'h1);
    chk("ill_result1", resp_result1, 32'h0);
    chk("ill_zero1", 32'(resp_zero1), 32'h0);
    chk("ill_tag1", 32'(resp_tag1), 32'd5);
    chk("ill_alu_ctrl", 32'(alu_ctrl), 32'h0);
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b00;
    chk("ill_consumed", 32'(resp_valid), 32'h0);

    // Both valid: req0 SUB 9-9, req1 OR F0|0F; req0 wins after last grant 1.
    req_valid = 2'b11;
    req_a0 = 32'd9; req_b0 = 32'd9; req_op0 = 4'b0110; req_tag0 = 4'd1;
    req_a1 = 32'hF0; req_b1 = 32'h0F; req_op1 = 4'b0001; req_tag1 = 4'd2;
    #1;
    chk("tie_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b10;
    #1;
    chk("tie_exec_ready", 32'(req_ready), 32'h0);
    chk("tie_exec_ctrl", 32'(alu_ctrl), 32'h6);
    step();
    chk("sub_resp_valid", 32'(resp_valid), 32'h1);
    chk("sub_result0", resp_result0, 32'h0);
    chk("sub_zero0", 32'(resp_zero0), 32'h1);
    // Req0 issues again with its response unconsumed: only req1 may win.
    req_valid = 2'b11; req_a0 = 32'hC; req_b0 = 32'hA; req_op0 = 4'b0000; req_tag0 = 4'd4;
    #1;
    chk("pend_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b01;
    chk("or_exec_ctrl", 32'(alu_ctrl), 32'h1);
    chk("or_exec_data1", alu_data1, 32'hF0);
    step();
    chk("or_resp_valid", 32'(resp_valid), 32'h3);
    chk("or_result1", resp_result1, 32'hFF);
    chk("or_zero1", 32'(resp_zero1), 32'h0);
    chk("or_tag1", 32'(resp_tag1), 32'd2);
    chk("blocked_ready", 32'(req_ready), 32'h0);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    #1;
    chk("after_consume_valid", 32'(resp_valid), 32'h2);
    chk("after_consume_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    chk("and_exec_data1", alu_data1, 32'hC);
    step();
    chk("and_resp_valid", 32'(resp_valid), 32'h3);
    chk("and_result0", resp_result0, 32'h8);
    chk("and_tag0", 32'(resp_tag0), 32'd4);
    resp_ready = 2'b11;
    step();
    resp_ready = 2'b00;
    chk("drain_both", 32'(resp_valid), 32'h0);

    // Reset during EXEC of SLT 3<4 drops the in-flight op.
    req_valid = 2'b01; req_a0 = 32'd3; req_b0 = 32'd4; req_op0 = 4'b0111; req_tag0 = 4'd6;
    step();
    req_valid = 2'b00;
    chk("slt_exec_ctrl", 32'(alu_ctrl), 32'h7);
    reset = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
    chk("midrst_alu_ctrl", 32'(alu_ctrl), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    step();
    reset = 1'b0;
    step();
    step();
    chk("no_stale_resp", 32'(resp_valid), 32'h0);
    req_valid = 2'b01; req_tag0 = 4'd7;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    step();
    chk("slt_resp_valid", 32'(resp_valid), 32'h1);
    chk("slt_result0", resp_result0, 32'd1);
    chk("slt_zero0", 32'(resp_zero0), 32'h0);
    chk("slt_tag0", 32'(resp_tag0), 32'd7);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;

    // Sustained both-valid: six grants alternate starting with requester 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = 4'b0010;
    req_a1 = 32'd2; req_b1 = 32'd2; req_op1 = 4'b0010;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] exp_grant;
      exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(exp_grant));
      step();
      step();
      chk($sformatf("rr_resp%0d", k), 32'(resp_valid), 32'(exp_grant));
    end
    req_valid = 2'b00;
    step();
    chk("rr_drained", 32'(resp_valid), 32'h0);
`ifdef ALU_ARB_PERF_CNT_EN
    chk("grant_cnt0", grant_cnt0, 32'd3);
    chk("grant_cnt1", grant_cnt1, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
